fetch_decode_unit: RTL

Instruction fetch and decode sequencer for the 16-bit basic computer. It owns PC, AR and IR, and drives the edge-triggered `read` strobe and 12-bit address of the word memory directly downstream. It captures each instruction word, resolves one level of indirect addressing, and presents a decoded instruction to the execute stage over a valid/ready handshake.

---
 rtl/basic_cpu_pkg.sv | 44 ++++
 rtl/fetch_decode_unit_opcode_decoder.sv | 18 +
 rtl/fetch_decode_unit.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/basic_cpu_pkg.sv
// Shared types and constants for the 16-bit basic computer fetch/decode path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: default widths, instruction field positions, opcode values and
// the fetch/decode sequencer state encoding.
package basic_cpu_pkg;

  // Default datapath widths.
  localparam int ADDR_W = 12;
  localparam int WORD_W = 16;

  // Instruction word field positions.
  localparam int I_BIT  = 15;  // indirect flag
  localparam int OP_HI  = 14;  // opcode msb
  localparam int OP_LO  = 12;  // opcode lsb
  localparam int AD_HI  = 11;  // address field msb (lsb is bit 0)

  // Memory-reference opcodes 0-6; opcode 7 is register/IO reference and
  // never goes through indirection.
  typedef enum logic [2:0] {
    OP_AND   = 3'd0,
    OP_ADD   = 3'd1,
    OP_LDA   = 3'd2,
    OP_STA   = 3'd3,
    OP_BUN   = 3'd4,
    OP_BSA   = 3'd5,
    OP_ISZ   = 3'd6,
    OP_REGIO = 3'd7
  } opcode_t;

  // Sequencer states.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_T0    = 3'd1,
    S_T1    = 3'd2,
    S_T2    = 3'd3,
    S_T3    = 3'd4,
    S_IND1  = 3'd5,
    S_IND2  = 3'd6,
    S_ISSUE = 3'd7
  } state_t;

endpackage

// File: rtl/fetch_decode_unit_opcode_decoder.sv
// Purpose: combinational 3-to-8 one-hot decode of the instruction opcode.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input.
//
// Ports:
//   op     - 3-bit opcode field
//   onehot - bit[op] set, all others clear
module opcode_decoder (
  input  logic [2:0] op,
  output logic [7:0] onehot
);

  always_comb begin
    onehot     = '0;
    onehot[op] = 1'b1;
  end

endmodule

// File: rtl/fetch_decode_unit.sv
// Purpose: fetch/decode sequencer owning PC, AR, IR; one-level indirect resolve.
// Latency: valid 4 cycles after fetch start (6 when indirect); 5-cycle issue rate.
// Backpressure: holds the decoded instruction stable in ISSUE until exec_ready.
//
// Ports:
//   clk, rst_n            - clock, async active-low reset
//   start                 - level; leaves IDLE and fetches at current PC
//   memout                - word returned by memory
//   mem_read, mem_addr    - read strobe (rising edge samples) and address (=AR)
//   ir, ar, pc, ind, dec  - decoded instruction presented to execute
//   instr_valid           - decoded instruction available
//   exec_ready            - execute accepts the instruction
//   pc_load, pc_load_val  - PC replacement, honoured only on the handshake
//   halt                  - return to IDLE after the handshake
module fetch_decode_unit
  import basic_cpu_pkg::*;
#(
  parameter int ADDR_W = basic_cpu_pkg::ADDR_W,
  parameter int WORD_W = basic_cpu_pkg::WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WORD_W-1:0] memout,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] ir,
  output logic [ADDR_W-1:0] ar,
  output logic [ADDR_W-1:0] pc,
  output logic              ind,
  output logic [7:0]        dec,
  output logic              instr_valid,
  input  logic              exec_ready,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  input  logic              halt
);

  state_t      state;
  state_t      state_nxt;
  logic        rd_nxt;
  logic        vld_nxt;
  logic        hs;
  logic [2:0]  ir_op;
  logic        needs_ind;
  logic [7:0]  dec_nxt;

  // instr_valid is only ever high while in ISSUE, so this is the handshake.
  assign hs       = instr_valid & exec_ready;
  assign mem_addr = ar;

  assign ir_op     = ir[OP_HI:OP_LO];
  // Register/IO instructions ignore the I bit.
  assign needs_ind = ir[I_BIT] & (opcode_t'(ir_op) != OP_REGIO);

  opcode_decoder u_opcode_decoder (
    .op     (ir_op),
    .onehot (dec_nxt)
  );

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Next state and next values of the registered strobes. mem_read and
  // instr_valid are registered from the next state so they are glitch-free
  // and coincide exactly with T1/IND1 and ISSUE respectively. T1 and IND1
  // are always separated by at least one other state, so the read strobe
  // always returns low between reads.
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    rd_nxt    = 1'b0;
    vld_nxt   = 1'b0;

    case (state)
      S_IDLE:  if (start) state_nxt = S_T0;
      S_T0:    state_nxt = S_T1;
      S_T1:    state_nxt = S_T2;
      S_T2:    state_nxt = S_T3;
      S_T3:    state_nxt = needs_ind ? S_IND1 : S_ISSUE;
      S_IND1:  state_nxt = S_IND2;
      S_IND2:  state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (hs) begin
          state_nxt = halt ? S_IDLE : S_T0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    rd_nxt  = (state_nxt == S_T1) || (state_nxt == S_IND1);
    vld_nxt = (state_nxt == S_ISSUE);
  end

  // ---------------------------------------------------------------------
  // Datapath registers. Reset discards any read in flight: the strobe
  // drops and nothing returned afterwards is captured until a new fetch.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= '0;
      ar          <= '0;
      ir          <= '0;
      ind         <= 1'b0;
      dec         <= '0;
      mem_read    <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      mem_read    <= rd_nxt;
      instr_valid <= vld_nxt;

      case (state)
        S_T0: begin
          ar <= pc;
        end
        S_T2: begin
          ir <= memout;
          pc <= pc + ADDR_W'(1);  // wraps modulo 2^ADDR_W
        end
        S_T3: begin
          ar  <= ADDR_W'(ir[AD_HI:0]);
          ind <= ir[I_BIT];
          dec <= dec_nxt;
        end
        S_IND2: begin
          ar <= ADDR_W'(memout[AD_HI:0]);
        end
        S_ISSUE: begin
          if (hs && pc_load) begin
            pc <= pc_load_val;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
